psum_accum: RTL and testbench

Partial-sum accumulation stage that sits directly downstream of the PE's 16x16 Booth multiplier. It accepts a stream of 32-bit signed Q7.24 products, sums a configurable number of them, and optionally adds a 16-bit Q3.12 partial sum arriving from the neighbouring PE. It then rounds and saturates the total to Q3.12 and presents it on a valid/ready output. This stage is the accumulate half of the PE's MAC datapath.

---
 rtl/pe_pkg.sv | 24 ++
 rtl/round_sat.sv | 37 +++
 rtl/psum_accum.sv | 152 +++++++++++++++
 tb/tb_psum_accum.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/pe_pkg.sv
// Shared PE definitions: fixed-point formats, saturation limits and the
// accumulate-stage state encoding.
package pe_pkg;

    localparam int DATA_W    = 16;
    localparam int FRAC_W    = 12;
    localparam int PROD_W    = 32;
    localparam int PROD_FRAC = 24;

    // Distance between the Q7.24 product grid and the Q3.12 output grid.
    localparam int RND_SHIFT = PROD_FRAC - FRAC_W;

    localparam logic [DATA_W-1:0] Q_MAX = 16'h7FFF;
    localparam logic [DATA_W-1:0] Q_MIN = 16'h8000;

    typedef enum logic [2:0] {
        IDLE,
        ACC,
        PSUM,
        SAT,
        OUT
    } acc_state_t;

endpackage

// File: rtl/round_sat.sv
// Round-half-up and saturate a wide 24-fractional-bit accumulator to Q3.12.
// Purely combinational; shared with the PE output stage.
module round_sat
    import pe_pkg::*;
#(
    parameter int ACC_W = 36
) (
    input  logic [ACC_W-1:0]  acc,
    output logic [DATA_W-1:0] res,
    output logic              clip
);

    // One extra bit so adding the rounding half can never wrap.
    localparam int EXT_W = ACC_W + 1;

    localparam logic signed [EXT_W-1:0] HALF = EXT_W'(1) << (RND_SHIFT - 1);
    localparam logic signed [EXT_W-1:0] HI   = EXT_W'(Q_MAX);
    localparam logic signed [EXT_W-1:0] LO   = $signed({{(EXT_W - DATA_W){1'b1}}, Q_MIN});

    logic signed [EXT_W-1:0] biased;
    logic signed [EXT_W-1:0] r;

    always_comb begin
        biased = $signed({acc[ACC_W-1], acc}) + HALF;
        r      = biased >>> RND_SHIFT;
        res    = r[DATA_W-1:0];
        clip   = 1'b0;
        if (r > HI) begin
            res  = Q_MAX;
            clip = 1'b1;
        end else if (r < LO) begin
            res  = Q_MIN;
            clip = 1'b1;
        end
    end

endmodule

// File: rtl/psum_accum.sv
// Partial-sum accumulate stage: sums cfg_len Q7.24 products, optionally adds
// a neighbour Q3.12 partial sum, then rounds/saturates to a Q3.12 result.
module psum_accum
    import pe_pkg::*;
#(
    parameter int LEN_W = 4,
    parameter int GUARD = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [LEN_W-1:0]  cfg_len,
    input  logic              cfg_use_psum,
    input  logic              prod_valid,
    output logic              prod_ready,
    input  logic [31:0]       prod_data,
    input  logic              psum_in_valid,
    output logic              psum_in_ready,
    input  logic [15:0]       psum_in_data,
    output logic              psum_out_valid,
    input  logic              psum_out_ready,
    output logic [15:0]       psum_out_data,
    output logic              sat_flag
);

    localparam int ACC_W = PROD_W + GUARD;

    acc_state_t state, state_nxt;

    logic [ACC_W-1:0]  acc;
    logic [LEN_W-1:0]  cnt;
    logic [LEN_W-1:0]  len_q;
    logic              use_psum_q;
    logic              sat_q;
    logic              prod_rdy;

    logic [LEN_W-1:0]  cfg_len_eff;
    logic [LEN_W-1:0]  cnt_inc;
    logic [ACC_W-1:0]  prod_ext;
    logic [ACC_W-1:0]  psum_ext;
    logic [DATA_W-1:0] rs_res;
    logic              rs_clip;

    assign cfg_len_eff = (cfg_len == '0) ? LEN_W'(1) : cfg_len;
    assign cnt_inc     = cnt + LEN_W'(1);
    assign prod_ext    = {{GUARD{prod_data[PROD_W-1]}}, prod_data};
    // Psum is aligned onto the accumulator's 24-bit fractional grid.
    assign psum_ext    = {{(ACC_W - DATA_W - RND_SHIFT){psum_in_data[DATA_W-1]}},
                          psum_in_data, {RND_SHIFT{1'b0}}};

    // Ready is forced low while reset is held so every output reads 0.
    assign prod_ready = prod_rdy & rst_n;
    assign sat_flag   = sat_q & (state == OUT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        prod_rdy       = 1'b0;
        psum_in_ready  = 1'b0;
        psum_out_valid = 1'b0;
        case (state)
            IDLE: begin
                prod_rdy = 1'b1;
                if (prod_valid) begin
                    if (cfg_len_eff == LEN_W'(1)) begin
                        state_nxt = cfg_use_psum ? PSUM : SAT;
                    end else begin
                        state_nxt = ACC;
                    end
                end
            end
            ACC: begin
                prod_rdy = 1'b1;
                if (prod_valid && (cnt_inc == len_q)) begin
                    state_nxt = use_psum_q ? PSUM : SAT;
                end
            end
            PSUM: begin
                psum_in_ready = 1'b1;
                if (psum_in_valid) begin
                    state_nxt = SAT;
                end
            end
            SAT: begin
                state_nxt = OUT;
            end
            OUT: begin
                psum_out_valid = 1'b1;
                if (psum_out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc           <= '0;
            cnt           <= '0;
            len_q         <= '0;
            use_psum_q    <= 1'b0;
            psum_out_data <= '0;
            sat_q         <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (prod_valid) begin
                        acc        <= prod_ext;
                        cnt        <= LEN_W'(1);
                        len_q      <= cfg_len_eff;
                        use_psum_q <= cfg_use_psum;
                    end
                end
                ACC: begin
                    if (prod_valid) begin
                        acc <= acc + prod_ext;
                        cnt <= cnt_inc;
                    end
                end
                PSUM: begin
                    if (psum_in_valid) begin
                        acc <= acc + psum_ext;
                    end
                end
                SAT: begin
                    psum_out_data <= rs_res;
                    sat_q         <= rs_clip;
                end
                default: begin
                end
            endcase
        end
    end

    round_sat #(
        .ACC_W (ACC_W)
    ) u_round_sat (
        .acc  (acc),
        .res  (rs_res),
        .clip (rs_clip)
    );

endmodule

// File: tb/tb_psum_accum.sv
// Directed bench for psum_accum: hand-computed Q3.12 results, latency,
// backpressure, psum wait and mid-operation reset.
module tb_psum_accum;

    localparam int LEN_W = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [LEN_W-1:0] cfg_len;
    logic             cfg_use_psum;
    logic             prod_valid;
    logic             prod_ready;
    logic [31:0]      prod_data;
    logic             psum_in_valid;
    logic             psum_in_ready;
    logic [15:0]      psum_in_data;
    logic             psum_out_valid;
    logic             psum_out_ready;
    logic [15:0]      psum_out_data;
    logic             sat_flag;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    psum_accum #(
        .LEN_W (LEN_W),
        .GUARD (4)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .cfg_len        (cfg_len),
        .cfg_use_psum   (cfg_use_psum),
        .prod_valid     (prod_valid),
        .prod_ready     (prod_ready),
        .prod_data      (prod_data),
        .psum_in_valid  (psum_in_valid),
        .psum_in_ready  (psum_in_ready),
        .psum_in_data   (psum_in_data),
        .psum_out_valid (psum_out_valid),
        .psum_out_ready (psum_out_ready),
        .psum_out_data  (psum_out_data),
        .sat_flag       (sat_flag)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one product and return 1ns after the edge that accepts it.
    task automatic feed(input logic [31:0] d);
        int waited = 0;
        prod_valid = 1'b1;
        prod_data  = d;
        while (!prod_ready && waited < 20) begin
            tick();
            waited++;
        end
        if (!prod_ready) chk("prod_ready_timeout", 32'(prod_ready), 32'd1);
        tick();
        prod_valid = 1'b0;
    endtask

    task automatic get_out(input string tag, input logic [15:0] exp_d, input logic exp_s);
        int waited = 0;
        while (!psum_out_valid && waited < 20) begin
            tick();
            waited++;
        end
        chk({tag, "_valid"}, 32'(psum_out_valid), 32'd1);
        chk({tag, "_data"},  32'(psum_out_data),  32'(exp_d));
        chk({tag, "_sat"},   32'(sat_flag),       32'(exp_s));
        psum_out_ready = 1'b1;
        tick();
        psum_out_ready = 1'b0;
    endtask

    task automatic run1(input string tag, input logic [LEN_W-1:0] len,
                        input logic [31:0] d, input logic [15:0] exp_d);
        cfg_len      = len;
        cfg_use_psum = 1'b0;
        feed(d);
        get_out(tag, exp_d, 1'b0);
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_prod_ready"}, 32'(prod_ready),     32'd0);
        chk({tag, "_psum_ready"}, 32'(psum_in_ready),  32'd0);
        chk({tag, "_out_valid"},  32'(psum_out_valid), 32'd0);
        chk({tag, "_out_data"},   32'(psum_out_data),  32'd0);
        chk({tag, "_sat"},        32'(sat_flag),       32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n          = 1'b0;
        cfg_len        = '0;
        cfg_use_psum   = 1'b0;
        prod_valid     = 1'b0;
        prod_data      = '0;
        psum_in_valid  = 1'b0;
        psum_in_data   = '0;
        psum_out_ready = 1'b0;
        #1;
        chk_zero_outputs("reset");
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Single product, latency: SAT one cycle, valid after the following edge.
        cfg_len      = 4'd1;
        cfg_use_psum = 1'b0;
        feed(32'h06F9_0000);
        chk("lat_sat_cycle", 32'(psum_out_valid), 32'd0);
        tick();
        chk("lat_out_cycle", 32'(psum_out_valid), 32'd1);
        get_out("single", 16'h6F90, 1'b0);

        // Cancellation; cfg_len change mid-row must be ignored.
        cfg_len = 4'd2;
        feed(32'h06F9_0000);
        cfg_len = 4'd0;
        feed(32'hF907_0000);
        get_out("cancel", 16'h0000, 1'b0);

        cfg_len = 4'd2;
        feed(32'h06F9_0000);
        feed(32'h06F9_0000);
        get_out("pos_sat", 16'h7FFF, 1'b1);

        cfg_len = 4'd3;
        feed(32'hF907_0000);
        feed(32'hF907_0000);
        feed(32'hF907_0000);
        get_out("neg_sat", 16'h8000, 1'b1);

        // Psum add with a late psum; a waiting product must not be taken.
        cfg_len      = 4'd1;
        cfg_use_psum = 1'b1;
        feed(32'h0100_0000);
        cfg_use_psum = 1'b0;
        prod_valid   = 1'b1;
        prod_data    = 32'h1234_5678;
        for (int i = 0; i < 3; i++) begin
            chk("psum_wait_prod_ready", 32'(prod_ready),    32'd0);
            chk("psum_wait_psum_ready", 32'(psum_in_ready), 32'd1);
            tick();
        end
        prod_valid    = 1'b0;
        psum_in_valid = 1'b1;
        psum_in_data  = 16'h1000;
        tick();
        psum_in_valid = 1'b0;
        chk("psum_taken", 32'(psum_in_ready), 32'd0);
        get_out("psum_add", 16'h2000, 1'b0);

        // Rounding boundaries (first one also covers cfg_len=0 as length 1).
        run1("rnd_half_up",   4'd0, 32'h0000_0800, 16'h0001);
        run1("rnd_below",     4'd1, 32'h0000_07FF, 16'h0000);
        run1("rnd_neg_half",  4'd1, 32'hFFFF_F800, 16'h0000);
        run1("rnd_neg_below", 4'd1, 32'hFFFF_F7FF, 16'hFFFF);

        // Output backpressure with the next product already waiting.
        cfg_len = 4'd1;
        feed(32'h06F9_0000);
        tick();
        prod_valid = 1'b1;
        prod_data  = 32'h0100_0000;
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid",      32'(psum_out_valid), 32'd1);
            chk("bp_data",       32'(psum_out_data),  32'h6F90);
            chk("bp_sat",        32'(sat_flag),       32'd0);
            chk("bp_prod_ready", 32'(prod_ready),     32'd0);
            tick();
        end
        psum_out_ready = 1'b1;
        tick();
        psum_out_ready = 1'b0;
        chk("bp_hs_valid", 32'(psum_out_valid), 32'd0);
        chk("bp_hs_ready", 32'(prod_ready),     32'd1);
        tick();
        prod_valid = 1'b0;
        chk("bp_next_taken", 32'(prod_ready), 32'd0);
        get_out("bp_next", 16'h1000, 1'b0);

        // Reset in the middle of a 4-product row.
        cfg_len = 4'd4;
        feed(32'h0300_0000);
        feed(32'h0300_0000);
        rst_n = 1'b0;
        #1;
        chk_zero_outputs("mid_rst");
        tick();
        rst_n = 1'b1;
        tick();
        run1("post_rst", 4'd1, 32'h0100_0000, 16'h1000);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
